// File: rtl/vdma_axi4s_to_axi4_burst.sv
// Video DMA write engine: takes an AXI4-Stream frame, splits each line into AXI4
// INCR bursts and writes it to a strided frame buffer, tracking outstanding bursts.
module vdma_axi4s_to_axi4_burst #(
  parameter int AXI4_ID_WIDTH   = 6,
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_SIZE  = 3,
  parameter int AXI4_LEN_WIDTH  = 8,
  parameter int STRIDE_WIDTH    = 14,
  parameter int H_WIDTH         = 12,
  parameter int V_WIDTH         = 12,
  parameter int INDEX_WIDTH     = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              aclk,
  input  logic                              areset,

  input  logic                              ctl_enable,
  input  logic                              ctl_update,
  output logic                              ctl_busy,
  output logic [INDEX_WIDTH-1:0]            ctl_index,
  output logic                              ctl_bresp_err,

  input  logic [AXI4_ADDR_WIDTH-1:0]        param_addr,
  input  logic [STRIDE_WIDTH-1:0]           param_stride,
  input  logic [H_WIDTH-1:0]                param_width,
  input  logic [V_WIDTH-1:0]                param_height,
  input  logic [AXI4_LEN_WIDTH-1:0]         param_awlen,

  output logic [AXI4_ID_WIDTH-1:0]          m_axi4_awid,
  output logic [AXI4_ADDR_WIDTH-1:0]        m_axi4_awaddr,
  output logic [AXI4_LEN_WIDTH-1:0]         m_axi4_awlen,
  output logic [2:0]                        m_axi4_awsize,
  output logic [1:0]                        m_axi4_awburst,
  output logic                              m_axi4_awlock,
  output logic [3:0]                        m_axi4_awcache,
  output logic [2:0]                        m_axi4_awprot,
  output logic [3:0]                        m_axi4_awqos,
  output logic [3:0]                        m_axi4_awregion,
  output logic                              m_axi4_awvalid,
  input  logic                              m_axi4_awready,

  output logic [(8<<AXI4_DATA_SIZE)-1:0]    m_axi4_wdata,
  output logic [(1<<AXI4_DATA_SIZE)-1:0]    m_axi4_wstrb,
  output logic                              m_axi4_wlast,
  output logic                              m_axi4_wvalid,
  input  logic                              m_axi4_wready,

  input  logic [AXI4_ID_WIDTH-1:0]          m_axi4_bid,
  input  logic [1:0]                        m_axi4_bresp,
  input  logic                              m_axi4_bvalid,
  output logic                              m_axi4_bready,

  input  logic                              s_axi4s_tuser,
  input  logic                              s_axi4s_tlast,
  input  logic [(8<<AXI4_DATA_SIZE)-1:0]    s_axi4s_tdata,
  input  logic                              s_axi4s_tvalid,
  output logic                              s_axi4s_tready
);

  localparam int DW  = 8 << AXI4_DATA_SIZE;
  localparam int SW  = 1 << AXI4_DATA_SIZE;
  localparam int CW  = ((H_WIDTH > AXI4_LEN_WIDTH) ? H_WIDTH : AXI4_LEN_WIDTH) + 1;
  localparam int CRW = CW + 9;
  localparam logic [CW-1:0]  CW_ONE  = CW'(1'b1);
  localparam logic [CRW-1:0] CRW_ONE = CRW'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t state_r, state_next_s;

  logic [AXI4_ADDR_WIDTH-1:0] addr_r;
  logic [STRIDE_WIDTH-1:0]    stride_r;
  logic [H_WIDTH-1:0]         width_r;
  logic [V_WIDTH-1:0]         height_r;
  logic [AXI4_LEN_WIDTH-1:0]  awlen_r;
  logic                       busy_r;
  logic [INDEX_WIDTH-1:0]     index_r;
  logic                       bresp_err_r;

  logic [H_WIDTH-1:0]         aw_rem_r;
  logic [V_WIDTH-1:0]         aw_line_r;
  logic [AXI4_ADDR_WIDTH-1:0] aw_addr_r;
  logic [AXI4_ADDR_WIDTH-1:0] aw_line_addr_r;
  logic                       aw_done_r;
  logic [AXI4_ADDR_WIDTH-1:0] awaddr_r;
  logic [AXI4_LEN_WIDTH-1:0]  awlen_out_r;
  logic                       awvalid_r;
  logic [CRW-1:0]             credit_r;
  logic [7:0]                 outstanding_r;

  logic [H_WIDTH-1:0]         w_rem_r;
  logic [V_WIDTH-1:0]         w_line_r;
  logic [AXI4_LEN_WIDTH-1:0]  w_bcnt_r;
  logic [DW-1:0]              wdata_r;
  logic                       wlast_r;
  logic                       wvalid_r;

  logic                       start_s;
  logic                       stop_s;
  logic                       run_init_s;
  logic                       tready_s;
  logic                       t_fire_s;
  logic                       w_slot_s;
  logic                       aw_load_s;
  logic                       aw_hs_s;
  logic                       aw_line_end_s;
  logic                       aw_last_line_s;
  logic [CW-1:0]              burst_beats_s;
  logic [AXI4_ADDR_WIDTH-1:0] stride_ext_s;
  logic                       w_burst_end_s;
  logic                       w_frame_end_s;
  logic                       zero_frame_s;
  logic                       drained_s;
  logic                       unused_s;

  assign burst_beats_s  = (CW'(aw_rem_r) > CW'(awlen_r)) ? (CW'(awlen_r) + CW_ONE) : CW'(aw_rem_r);
  assign aw_line_end_s  = (CW'(aw_rem_r) == burst_beats_s);
  assign aw_last_line_s = (aw_line_r == (height_r - V_WIDTH'(1'b1)));
  assign stride_ext_s   = AXI4_ADDR_WIDTH'(stride_r);
  assign aw_hs_s        = awvalid_r && m_axi4_awready;
  assign aw_load_s      = (state_r == ST_RUN) && !aw_done_r && !awvalid_r &&
                          (outstanding_r < 8'(MAX_OUTSTANDING));

  assign w_slot_s       = !wvalid_r || m_axi4_wready;
  assign t_fire_s       = s_axi4s_tvalid && tready_s && (state_r == ST_RUN);
  assign w_burst_end_s  = (w_bcnt_r == awlen_r) || (w_rem_r == H_WIDTH'(1'b1));
  assign w_frame_end_s  = (w_rem_r == H_WIDTH'(1'b1)) && (w_line_r == (height_r - V_WIDTH'(1'b1)));
  assign zero_frame_s   = (width_r == {H_WIDTH{1'b0}}) || (height_r == {V_WIDTH{1'b0}});
  assign drained_s      = (outstanding_r == 8'd0) && !awvalid_r && !wvalid_r;

  assign ctl_busy        = busy_r;
  assign ctl_index       = index_r;
  assign ctl_bresp_err   = bresp_err_r;
  assign m_axi4_awid     = {AXI4_ID_WIDTH{1'b0}};
  assign m_axi4_awaddr   = awaddr_r;
  assign m_axi4_awlen    = awlen_out_r;
  assign m_axi4_awsize   = 3'(AXI4_DATA_SIZE);
  assign m_axi4_awburst  = 2'b01;
  assign m_axi4_awlock   = 1'b0;
  assign m_axi4_awcache  = 4'b0001;
  assign m_axi4_awprot   = 3'b000;
  assign m_axi4_awqos    = 4'b0000;
  assign m_axi4_awregion = 4'b0000;
  assign m_axi4_awvalid  = awvalid_r;
  assign m_axi4_wdata    = wdata_r;
  assign m_axi4_wstrb    = {SW{1'b1}};
  assign m_axi4_wlast    = wlast_r;
  assign m_axi4_wvalid   = wvalid_r;
  assign m_axi4_bready   = 1'b1;
  assign s_axi4s_tready  = tready_s;
  assign unused_s        = ^{s_axi4s_tlast, m_axi4_bid};

  // Frame state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; the tuser beat is held back in SKIP so RUN writes it first.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    stop_s       = 1'b0;
    run_init_s   = 1'b0;
    tready_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ctl_enable) begin
          start_s      = 1'b1;
          state_next_s = ST_SKIP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SKIP: begin
        if (zero_frame_s) begin
          state_next_s = ST_DRAIN;
        end else if (s_axi4s_tvalid && s_axi4s_tuser) begin
          run_init_s   = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          tready_s     = 1'b1;
        end
      end
      ST_RUN: begin
        tready_s = w_slot_s && (credit_r != {CRW{1'b0}});
        if (s_axi4s_tvalid && tready_s && w_frame_end_s) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drained_s) begin
          if (ctl_enable) begin
            start_s      = 1'b1;
            state_next_s = ST_SKIP;
          end else begin
            stop_s       = 1'b1;
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Control status and shadow parameter capture at frame start.
  always_ff @(posedge aclk) begin
    if (areset) begin
      busy_r   <= 1'b0;
      index_r  <= {INDEX_WIDTH{1'b0}};
      addr_r   <= {AXI4_ADDR_WIDTH{1'b0}};
      stride_r <= {STRIDE_WIDTH{1'b0}};
      width_r  <= {H_WIDTH{1'b0}};
      height_r <= {V_WIDTH{1'b0}};
      awlen_r  <= {AXI4_LEN_WIDTH{1'b0}};
    end else if (start_s) begin
      busy_r  <= 1'b1;
      index_r <= index_r + INDEX_WIDTH'(1'b1);
      if (ctl_update) begin
        addr_r   <= param_addr;
        stride_r <= param_stride;
        width_r  <= param_width;
        height_r <= param_height;
        awlen_r  <= param_awlen;
      end
    end else if (stop_s) begin
      busy_r <= 1'b0;
    end
  end

  // Burst address generator, AW channel register and W-beat credit.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_rem_r       <= {H_WIDTH{1'b0}};
      aw_line_r      <= {V_WIDTH{1'b0}};
      aw_addr_r      <= {AXI4_ADDR_WIDTH{1'b0}};
      aw_line_addr_r <= {AXI4_ADDR_WIDTH{1'b0}};
      aw_done_r      <= 1'b0;
      awaddr_r       <= {AXI4_ADDR_WIDTH{1'b0}};
      awlen_out_r    <= {AXI4_LEN_WIDTH{1'b0}};
      awvalid_r      <= 1'b0;
      credit_r       <= {CRW{1'b0}};
    end else begin
      if (aw_hs_s) begin
        awvalid_r <= 1'b0;
      end
      if (run_init_s) begin
        aw_rem_r       <= width_r;
        aw_line_r      <= {V_WIDTH{1'b0}};
        aw_addr_r      <= addr_r;
        aw_line_addr_r <= addr_r;
        aw_done_r      <= 1'b0;
        credit_r       <= {CRW{1'b0}};
      end else begin
        credit_r <= credit_r + (aw_load_s ? CRW'(burst_beats_s) : {CRW{1'b0}})
                             - (t_fire_s ? CRW_ONE : {CRW{1'b0}});
        if (aw_load_s) begin
          awaddr_r    <= aw_addr_r;
          awlen_out_r <= AXI4_LEN_WIDTH'(burst_beats_s - CW_ONE);
          awvalid_r   <= 1'b1;
          if (aw_line_end_s) begin
            aw_rem_r       <= width_r;
            aw_line_r      <= aw_line_r + V_WIDTH'(1'b1);
            aw_line_addr_r <= aw_line_addr_r + stride_ext_s;
            aw_addr_r      <= aw_line_addr_r + stride_ext_s;
            aw_done_r      <= aw_last_line_s;
          end else begin
            aw_rem_r  <= aw_rem_r - H_WIDTH'(burst_beats_s);
            aw_addr_r <= aw_addr_r + (AXI4_ADDR_WIDTH'(burst_beats_s) << AXI4_DATA_SIZE);
          end
        end
      end
    end
  end

  // Outstanding burst count and sticky write-response error; B beats after reset are not counted.
  always_ff @(posedge aclk) begin
    if (areset) begin
      outstanding_r <= 8'd0;
      bresp_err_r   <= 1'b0;
    end else begin
      case ({aw_hs_s, m_axi4_bvalid})
        2'b10: outstanding_r <= outstanding_r + 8'd1;
        2'b01: begin
          if (outstanding_r != 8'd0) begin
            outstanding_r <= outstanding_r - 8'd1;
          end
        end
        default: outstanding_r <= outstanding_r;
      endcase
      if (m_axi4_bvalid && (m_axi4_bresp != 2'b00)) begin
        bresp_err_r <= 1'b1;
      end
    end
  end

  // W register stage with per-line burst tracking for wlast.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_rem_r  <= {H_WIDTH{1'b0}};
      w_line_r <= {V_WIDTH{1'b0}};
      w_bcnt_r <= {AXI4_LEN_WIDTH{1'b0}};
      wdata_r  <= {DW{1'b0}};
      wlast_r  <= 1'b0;
      wvalid_r <= 1'b0;
    end else begin
      if (run_init_s) begin
        w_rem_r  <= width_r;
        w_line_r <= {V_WIDTH{1'b0}};
        w_bcnt_r <= {AXI4_LEN_WIDTH{1'b0}};
      end else if (t_fire_s) begin
        if (w_burst_end_s) begin
          w_bcnt_r <= {AXI4_LEN_WIDTH{1'b0}};
        end else begin
          w_bcnt_r <= w_bcnt_r + AXI4_LEN_WIDTH'(1'b1);
        end
        if (w_rem_r == H_WIDTH'(1'b1)) begin
          w_rem_r  <= width_r;
          w_line_r <= w_line_r + V_WIDTH'(1'b1);
        end else begin
          w_rem_r  <= w_rem_r - H_WIDTH'(1'b1);
        end
      end
      if (w_slot_s) begin
        wvalid_r <= t_fire_s;
        if (t_fire_s) begin
          wdata_r <= s_axi4s_tdata;
          wlast_r <= w_burst_end_s;
        end
      end
    end
  end

endmodule
